// File: rtl/usb_cdc_pkg.sv
// Shared constants for the USB CDC byte FIFOs (RX path, TX path and wrapper).
package usb_cdc_pkg;
  localparam int USB_CDC_FIFO_DW = 8;
  localparam int USB_CDC_FIFO_AW = 4;
endpackage

// File: rtl/usb_cdc_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
// Kept on its own so it can later be replaced by an SRAM macro.
module usb_cdc_fifo_mem
  import usb_cdc_pkg::*;
#(
  parameter int DW = USB_CDC_FIFO_DW,
  parameter int AW = USB_CDC_FIFO_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [2**AW];

  // Storage write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/usb_cdc_fifo_ex.sv
// First-word-fall-through byte FIFO with full-range level, thresholds,
// sticky overflow/underflow flags and a peak-level watermark.
module usb_cdc_fifo_ex
  import usb_cdc_pkg::*;
#(
  parameter int DW = USB_CDC_FIFO_DW,
  parameter int AW = USB_CDC_FIFO_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr,
  input  logic [DW-1:0] w_data,
  input  logic          rd,
  output logic [DW-1:0] r_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  input  logic [AW:0]   th_hi,
  input  logic [AW:0]   th_lo,
  output logic          above_th,
  output logic          below_th,
  output logic          ovf,
  output logic          udf,
  output logic [AW:0]   peak,
  input  logic          stat_clr
);

  localparam int            DEPTH     = 2**AW;
  localparam logic [AW:0]   DEPTH_LVL = DEPTH[AW:0];
  localparam logic [AW:0]   LVL_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] w_ptr_r, r_ptr_r, w_ptr_next_s, r_ptr_next_s;
  logic [AW:0]   level_r, level_next_s, peak_r, peak_next_s;
  logic          empty_r, full_r, ovf_r, udf_r;
  logic          ovf_next_s, udf_next_s;
  logic          wr_acc_s, rd_acc_s, ovf_set_s, udf_set_s;

  // Accept decisions, next pointers/level and sticky-flag/watermark updates
  always_comb begin
    wr_acc_s     = wr & (~full_r | rd) & ~flush;
    rd_acc_s     = rd & ~empty_r & ~flush;
    ovf_set_s    = wr & ~rd & full_r & ~flush;
    udf_set_s    = rd & empty_r & ~flush;
    w_ptr_next_s = w_ptr_r;
    r_ptr_next_s = r_ptr_r;
    level_next_s = level_r;
    if (flush) begin
      w_ptr_next_s = {AW{1'b0}};
      r_ptr_next_s = {AW{1'b0}};
      level_next_s = {(AW+1){1'b0}};
    end else begin
      if (wr_acc_s) w_ptr_next_s = w_ptr_r + PTR_ONE;
      else          w_ptr_next_s = w_ptr_r;
      if (rd_acc_s) r_ptr_next_s = r_ptr_r + PTR_ONE;
      else          r_ptr_next_s = r_ptr_r;
      case ({wr_acc_s, rd_acc_s})
        2'b10:   level_next_s = level_r + LVL_ONE;
        2'b01:   level_next_s = level_r - LVL_ONE;
        default: level_next_s = level_r;
      endcase
    end
    // A set event in the same cycle takes precedence over stat_clr
    if (ovf_set_s)     ovf_next_s = 1'b1;
    else if (stat_clr) ovf_next_s = 1'b0;
    else               ovf_next_s = ovf_r;
    if (udf_set_s)     udf_next_s = 1'b1;
    else if (stat_clr) udf_next_s = 1'b0;
    else               udf_next_s = udf_r;
    if (stat_clr || (level_next_s > peak_r)) peak_next_s = level_next_s;
    else                                     peak_next_s = peak_r;
  end

  // Control and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr_r <= {AW{1'b0}};
      r_ptr_r <= {AW{1'b0}};
      level_r <= {(AW+1){1'b0}};
      peak_r  <= {(AW+1){1'b0}};
      empty_r <= 1'b1;
      full_r  <= 1'b0;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
    end else begin
      w_ptr_r <= w_ptr_next_s;
      r_ptr_r <= r_ptr_next_s;
      level_r <= level_next_s;
      peak_r  <= peak_next_s;
      empty_r <= (level_next_s == {(AW+1){1'b0}});
      full_r  <= (level_next_s == DEPTH_LVL);
      ovf_r   <= ovf_next_s;
      udf_r   <= udf_next_s;
    end
  end

  usb_cdc_fifo_mem #(.DW(DW), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (wr_acc_s),
    .waddr (w_ptr_r),
    .wdata (w_data),
    .raddr (r_ptr_r),
    .rdata (r_data)
  );

  assign level    = level_r;
  assign peak     = peak_r;
  assign empty    = empty_r;
  assign full     = full_r;
  assign ovf      = ovf_r;
  assign udf      = udf_r;
  assign above_th = (level_r > th_hi);
  assign below_th = (level_r < th_lo);

endmodule

// File: tb/tb_usb_cdc_fifo_ex.sv
// Self-checking bench for usb_cdc_fifo_ex: directed boundary scenarios plus
// randomized traffic, checked against a queue-based reference model.
module tb_usb_cdc_fifo_ex;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n, flush, wr, rd, stat_clr;
  logic [DW-1:0] w_data;
  logic [DW-1:0] r_data;
  logic          empty, full, above_th, below_th, ovf, udf;
  logic [AW:0]   level, peak, th_hi, th_lo;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  int  m_peak;
  bit  m_ovf, m_udf;

  usb_cdc_fifo_ex #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr(wr), .w_data(w_data),
    .rd(rd), .r_data(r_data), .empty(empty), .full(full), .level(level),
    .th_hi(th_hi), .th_lo(th_lo), .above_th(above_th), .below_th(below_th),
    .ovf(ovf), .udf(udf), .peak(peak), .stat_clr(stat_clr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("level", 32'(level), 32'(q.size()));
    check_eq("empty", 32'(empty), 32'(q.size() == 0));
    check_eq("full", 32'(full), 32'(q.size() == DEPTH));
    check_eq("ovf", 32'(ovf), 32'(m_ovf));
    check_eq("udf", 32'(udf), 32'(m_udf));
    check_eq("peak", 32'(peak), 32'(m_peak));
    check_eq("above_th", 32'(above_th), 32'(q.size() > int'(th_hi)));
    check_eq("below_th", 32'(below_th), 32'(q.size() < int'(th_lo)));
    if (q.size() > 0) check_eq("r_data", 32'(r_data), 32'(q[0]));
  endtask

  // Apply the current inputs over one clock edge, advance the model, then check.
  task automatic step();
    bit s_ovf, s_udf, do_rd, do_wr;
    int n;
    @(posedge clk);
    n = q.size();
    s_ovf = 1'b0;
    s_udf = 1'b0;
    if (flush) begin
      q.delete();
    end else begin
      do_rd = rd && (n > 0);
      do_wr = wr && ((n < DEPTH) || rd);
      s_udf = rd && (n == 0);
      s_ovf = wr && !rd && (n == DEPTH);
      if (do_rd) void'(q.pop_front());
      if (do_wr) q.push_back(w_data);
    end
    if (stat_clr) begin
      m_ovf  = s_ovf;
      m_udf  = s_udf;
      m_peak = q.size();
    end else begin
      m_ovf = m_ovf | s_ovf;
      m_udf = m_udf | s_udf;
      if (q.size() > m_peak) m_peak = q.size();
    end
    #1;
    check_all();
  endtask

  task automatic op(input bit w, input bit r, input logic [DW-1:0] d);
    wr = w; rd = r; w_data = d;
    step();
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    m_peak = 0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr = 1'b0; rd = 1'b0; stat_clr = 1'b0;
    w_data = 8'h00; th_hi = 5'd12; th_lo = 5'd4;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    // Threshold flags follow threshold inputs combinationally
    th_lo = 5'd0; #1;
    check_eq("below_th_live0", 32'(below_th), 32'd0);
    th_lo = 5'd4; #1;
    check_eq("below_th_live1", 32'(below_th), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill 0x00..0x0F, then drain in order
    for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b0, 8'(i));
    check_eq("fill_full", 32'(full), 32'd1);
    check_eq("fill_peak", 32'(peak), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      check_eq("drain_data", 32'(r_data), 32'(i));
      op(1'b0, 1'b1, 8'h00);
    end
    check_eq("drain_empty", 32'(empty), 32'd1);

    // Overflow while full, underflow while empty, then stat_clr
    for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    op(1'b1, 1'b0, 8'hAA);
    check_eq("ovf_set", 32'(ovf), 32'd1);
    for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b1, 8'h00);
    op(1'b0, 1'b1, 8'h00);
    check_eq("udf_set", 32'(udf), 32'd1);
    stat_clr = 1'b1; step(); stat_clr = 1'b0;
    check_eq("stat_clr_peak", 32'(peak), 32'd0);

    // Simultaneous read/write at full and at empty
    for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b0, 8'(8'h30 + i));
    op(1'b1, 1'b1, 8'hC3);
    check_eq("rdwr_full_level", 32'(level), 32'd16);
    check_eq("rdwr_full_head", 32'(r_data), 32'h31);
    for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b1, 8'h00);
    op(1'b1, 1'b1, 8'h55);
    check_eq("rdwr_empty_data", 32'(r_data), 32'h55);
    check_eq("rdwr_empty_udf", 32'(udf), 32'd1);

    // Wrap-around at constant level 3
    op(1'b1, 1'b0, 8'h56);
    op(1'b1, 1'b0, 8'h57);
    for (int i = 0; i < 40; i++) op(1'b1, 1'b1, 8'($urandom_range(0, 255)));
    check_eq("wrap_level", 32'(level), 32'd3);

    // Flush with a concurrent write
    for (int i = 0; i < 3; i++) op(1'b0, 1'b1, 8'h00);
    stat_clr = 1'b1; step(); stat_clr = 1'b0;
    for (int i = 0; i < 9; i++) op(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    flush = 1'b1; op(1'b1, 1'b0, 8'hEE); flush = 1'b0;
    check_eq("flush_peak", 32'(peak), 32'd9);
    check_eq("flush_empty", 32'(empty), 32'd1);

    // Asynchronous reset between edges at level 5
    for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    wr = 1'b1; w_data = 8'h99;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst_level", 32'(level), 32'd0);
    check_eq("arst_empty", 32'(empty), 32'd1);
    wr = 1'b0;
    @(posedge clk); #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    op(1'b1, 1'b0, 8'h42);
    check_eq("arst_first_wr", 32'(level), 32'd1);

    // Randomized traffic with shifting read/write bias
    for (int seg = 0; seg < 12; seg++) begin
      int pw, pr;
      pw = (seg % 3 == 0) ? 80 : ((seg % 3 == 1) ? 20 : 50);
      pr = 100 - pw;
      for (int i = 0; i < 150; i++) begin
        wr       = ($urandom_range(0, 99) < pw);
        rd       = ($urandom_range(0, 99) < pr);
        w_data   = 8'($urandom_range(0, 255));
        flush    = ($urandom_range(0, 99) < 2);
        stat_clr = ($urandom_range(0, 99) < 3);
        if ($urandom_range(0, 99) < 5) begin
          th_hi = 5'($urandom_range(0, 16));
          th_lo = 5'($urandom_range(0, 16));
        end
        step();
      end
    end
    wr = 1'b0; rd = 1'b0; flush = 1'b0; stat_clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #500000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/usb_cdc_fifo_ex.md
# usb_cdc_fifo_ex

Parametrised successor to the CDC wrapper's byte FIFO, used for both the RX (USB→host bus) and TX (bus→USB) paths in the `clk` domain. It adds three things:
- a full-range level count (0..DEPTH inclusive);
- correct simultaneous read/write at the empty and full boundaries;
- synchronous flush, hi/lo threshold flags, sticky overflow/underflow error flags and a peak-level watermark for firmware diagnostics.

## Interface
- `DW`, 8, data width in bits
- `AW`, 4, address width; DEPTH = 2**AW entries
- `clk`  in  1  single clock for all state
- `rst_n`  in  1  reset, asynchronous, active-low
- `flush`  in  1  synchronous clear of FIFO contents
- `wr`  in  1  write request
- `w_data`  in  DW  write data
- `rd`  in  1  read request; pops the head entry
- `r_data`  out  DW  head entry (first-word-fall-through)
- `empty`  out  1  no entries held
- `full`  out  1  DEPTH entries held
- `level`  out  AW+1  current entry count, 0..DEPTH
- `th_hi`  in  AW+1  upper threshold
- `th_lo`  in  AW+1  lower threshold
- `above_th`  out  1  level > th_hi
- `below_th`  out  1  level < th_lo
- `ovf`  out  1  sticky: write dropped because the FIFO was full
- `udf`  out  1  sticky: read while empty
- `peak`  out  AW+1  highest level since reset or stat_clr
- `stat_clr`  in  1  clears ovf, udf and peak

## Operation
- Write accepted when `wr & (~full | rd)`. Read accepted when `rd & ~empty`.
- Accepted write stores `w_data` at `w_ptr`. Pointers are AW bits and wrap modulo DEPTH.
- Level update:
  - write only: +1
  - read only: −1
  - both accepted: unchanged, both pointers advance
- `rd & wr` while empty: the write is accepted, the read is ignored, `udf` is set, level becomes 1.
- `rd & wr` while full: both are accepted, level stays DEPTH, no `ovf`.
- `wr & ~rd` while full: data is dropped, state is unchanged, `ovf` is set.
- `rd` while empty: state is unchanged, `udf` is set.
- `flush` has priority over `wr`/`rd`:
  - pointers and level go to 0, `empty`=1, `full`=0;
  - `wr`/`rd` in the same cycle are ignored and do not set `ovf`/`udf`;
  - `ovf`, `udf` and `peak` are unaffected.
- `stat_clr`: `ovf`/`udf` go to 0 and `peak` loads the current `level_next`. A set event in the same cycle wins over the clear.
- `peak` updates to `level_next` whenever `level_next` > `peak`.
- `r_data` is `mem[r_ptr]`, combinational from the registered pointer. Its value while `empty` is don't-care; storage is not reset.
- `above_th`/`below_th` are combinational compares of the registered `level` against the live `th_hi`/`th_lo`, unsigned, AW+1 bits.

## Timing
- Reset values:
  - `empty`=1, `full`=0, `level`=0, `peak`=0
  - `ovf`=0, `udf`=0
  - `below_th` = (0 < `th_lo`)
  - `above_th`=0
  - `r_data` undefined
- Every accepted operation is reflected in `level`, `empty`, `full`, `peak`, `ovf` and `udf` on the following clock edge; all of these are registered.
- Write-to-read latency: a word written at edge N is visible on `r_data` and `empty`=0 after edge N, so it can be read at edge N+1.
- Threshold flags: one cycle after a level change, zero cycles after a threshold change.
- Reset asserted mid-operation clears all state immediately. The first operation is accepted on the first edge after `rst_n` deasserts.

## Structure
- Shared package `usb_cdc_pkg`: default `USB_CDC_FIFO_DW`=8 and `USB_CDC_FIFO_AW`=4 constants, shared by the RX and TX instances and the wrapper.
- Sub-module `usb_cdc_fifo_mem`:
  - DW×DEPTH register array with one synchronous write port and one asynchronous read port;
  - no reset;
  - keeps storage separable for a later SRAM macro swap.
- Control, level, flags and watermark live in `usb_cdc_fifo_ex`.

## Test plan
- Fill: 16 writes of 0x00..0x0F with `th_hi`=12 → `level` 1..16, `full`=1 at 16, `above_th`=1 from level 13, `peak`=16, then 16 reads return 0x00..0x0F in order and `empty`=1.
- Overflow/underflow: write 0xAA while full → `ovf`=1, data dropped, `level`=16. Read while empty → `udf`=1, `level`=0. `stat_clr` → both flags 0 and `peak`=0.
- Simultaneous boundaries:
  - `rd&wr` while full → `level` stays 16, head advances, no `ovf`;
  - `rd&wr` while empty with 0x55 → `level`=1, `r_data`=0x55, `udf`=1.
- Wrap-around: 40 interleaved write/read pairs at `level` 3 → data order preserved across pointer wrap, `level` constant at 3.
- Flush: at `level`=9 assert `flush` with `wr` → `level`=0, `empty`=1, the write is ignored, `peak` stays 9.
- Async reset mid-burst: drop `rst_n` between edges at `level`=5 → `level`=0 and `empty`=1 immediately, without a clock edge.
